// File: rtl/vga_line_fetch.sv
// Ping-pong line buffer feeding the 640x480 VGA timing generator: prefetches framebuffer lines
// over a pipelined read port and serves the pixel colour combinationally.
module vga_line_fetch #(
  parameter int          H_PIXELS = 640,
  parameter int          V_LINES  = 480,
  parameter logic [31:0] FB_BASE  = 32'hA100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  output logic [23:0] vga_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        fetch_busy,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;
  typedef enum logic [1:0] {SU_LINE0 = 2'd0, SU_LINE1 = 2'd1, SU_LAST = 2'd2, SU_DONE = 2'd3} su_t;

  logic [23:0] line_buf [2][H_PIXELS];

  state_t      state;
  su_t         su;
  logic        disp_sel;
  logic        fill_sel;
  logic        valid_d;
  logic [9:0]  req_cnt;
  logic [9:0]  resp_cnt;
  logic [31:0] line_base_p0;

  logic        line_end;
  logic        req_fire;
  logic        req_last;
  logic        resp_fire;
  logic        resp_last;
  logic        start_fetch;
  logic        start_sel;
  logic [31:0] start_addr;
  logic        unused_resp_hi;

  // Byte offset of line (v+2) mod V_LINES; the constant multiply sits in its own register stage.
  function automatic logic [31:0] next_line_offset(input logic [9:0] v);
    logic [10:0] nl;
    nl = {1'b0, v} + 11'd2;
    if (nl >= 11'(V_LINES)) nl = nl - 11'(V_LINES);
    return 32'(nl) * 32'(H_PIXELS * 4);
  endfunction

  assign line_end       = valid_d & ~valid;
  assign req_fire       = mem_req_valid & mem_req_ready;
  assign req_last       = req_fire && (req_cnt == 10'(H_PIXELS - 1));
  assign resp_fire      = mem_resp_valid && (state != IDLE);
  assign resp_last      = resp_fire && (resp_cnt == 10'(H_PIXELS - 1));
  assign vga_data       = valid ? line_buf[disp_sel][h_addr] : 24'h0;
  assign unused_resp_hi = ^mem_resp_data[31:24];

  // Stage p0: base of the line two ahead of the one being displayed, tracked while video is active
  always_ff @(posedge clk) begin
    if (valid) line_base_p0 <= next_line_offset(v_addr);
  end

  always_comb begin
    start_fetch = 1'b0;
    start_sel   = 1'b0;
    start_addr  = FB_BASE;
    if (state == IDLE) begin
      case (su)
        SU_LINE0: start_fetch = 1'b1;
        SU_LINE1: begin
          start_fetch = 1'b1;
          start_sel   = 1'b1;
          start_addr  = FB_BASE + 32'(H_PIXELS * 4);
        end
        SU_DONE: if (line_end) begin
          start_fetch = 1'b1;
          start_sel   = disp_sel;
          start_addr  = FB_BASE + line_base_p0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      su            <= SU_LINE0;
      disp_sel      <= 1'b0;
      fill_sel      <= 1'b0;
      valid_d       <= 1'b0;
      req_cnt       <= 10'd0;
      resp_cnt      <= 10'd0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= FB_BASE;
      fetch_busy    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      valid_d <= valid;
      case (state)
        IDLE: begin
          case (su)
            SU_LINE0: su <= SU_LINE1;
            SU_LINE1: su <= SU_LAST;
            SU_LAST:  su <= SU_DONE;
            default:  ;
          endcase
          if (start_fetch) begin
            state         <= REQ;
            fill_sel      <= start_sel;
            mem_req_addr  <= start_addr;
            mem_req_valid <= 1'b1;
            fetch_busy    <= 1'b1;
            req_cnt       <= 10'd0;
            resp_cnt      <= 10'd0;
            if (su == SU_DONE) disp_sel <= ~disp_sel;
          end
        end
        REQ, DRAIN: begin
          if (req_fire) begin
            req_cnt      <= req_cnt + 10'd1;
            mem_req_addr <= mem_req_addr + 32'd4;
          end
          if (resp_fire) resp_cnt <= resp_cnt + 10'd1;
          // The final response can coincide with the final acceptance only with a zero-latency memory
          if (resp_last) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            fetch_busy    <= 1'b0;
          end else if (req_last) begin
            state         <= DRAIN;
            mem_req_valid <= 1'b0;
          end
          if (line_end && (su == SU_DONE)) underrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resp_fire) line_buf[fill_sel][resp_cnt] <= mem_resp_data[23:0];
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a 2-cycle-latency memory model whose words encode
// line and column so buffer contents can be checked through vga_data.
module tb_vga_line_fetch;
  localparam logic [31:0] FB = 32'hA100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_addr = 10'd0;
  logic [9:0]  v_addr = 10'd0;
  logic        valid = 1'b0;
  logic [23:0] vga_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        fetch_busy;
  logic        underrun;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] req_log[$];
  int          resp_total = 0;
  logic        p1_v;
  logic [31:0] p1_a;

  vga_line_fetch dut (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .valid(valid),
    .vga_data(vga_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .fetch_busy(fetch_busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix_word(input logic [31:0] a);
    logic [31:0] w, ln, x;
    w  = (a - FB) >> 2;
    ln = w / 640;
    x  = w % 640;
    return {8'hEE, x[7:0], 8'h55 ^ ln[7:0], 8'hAA};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_v           <= 1'b0;
      p1_a           <= 32'd0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= 32'd0;
    end else begin
      p1_v           <= mem_req_valid & mem_req_ready;
      p1_a           <= mem_req_addr;
      mem_resp_valid <= p1_v;
      mem_resp_data  <= pix_word(p1_a);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
      if (mem_resp_valid) resp_total++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input logic [9:0] v);
    v_addr = v;
    h_addr = 10'd5;
    valid  = 1'b1;
    repeat (4) step();
    valid = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!fetch_busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b0; mem_req_ready = 1'b1;
    repeat (3) step();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b need 0", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== FB) begin n_fail++; $display("FAIL rst_req_addr: got %h need %h", mem_req_addr, FB); end
    n_cmp++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b need 0", fetch_busy); end
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b need 0", underrun); end
    n_cmp++; if (vga_data !== 24'h0) begin n_fail++; $display("FAIL rst_vga_data: got %h need 000000", vga_data); end
  endtask

  task automatic startup_sequence(input string tag);
    bit seen1279;
    int bad;
    seen1279 = 1'b0;
    req_log.delete();
    resp_total = 0;
    mem_req_ready = 1'b1;
    rst = 1'b1;
    step();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== FB) begin n_fail++; $display("FAIL %s_first_req: got valid=%b addr=%h need 1 %h", tag, mem_req_valid, mem_req_addr, FB); end
    for (int c = 0; c < 4000; c++) begin
      step();
      if (resp_total == 1279 && !seen1279) begin
        seen1279 = 1'b1;
        n_cmp++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_1279: got %b need 1", tag, fetch_busy); end
      end
      if (resp_total >= 1280) break;
    end
    n_cmp++; if (resp_total != 1280 || fetch_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_fall: resp=%0d busy=%b need 1280 and 0", tag, resp_total, fetch_busy); end
    repeat (3) step();
    bad = -1;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] !== FB + 32'(4 * i)) begin bad = i; break; end
    n_cmp++; if (req_log.size() != 1280 || bad >= 0) begin n_fail++; $display("FAIL %s_req_order: count=%0d first_bad=%0d need 1280 from %h", tag, req_log.size(), bad, FB); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL %s_idle: req_valid=%b need 0", tag, mem_req_valid); end
  endtask

  task automatic test_startup();
    startup_sequence("startup");
  endtask

  task automatic test_display();
    valid = 1'b1; v_addr = 10'd0; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0555AA) begin n_fail++; $display("FAIL disp_h5: got %h need 0555AA", vga_data); end
    h_addr = 10'd639; #1;
    n_cmp++; if (vga_data !== 24'h7F55AA) begin n_fail++; $display("FAIL disp_h639: got %h need 7F55AA", vga_data); end
    h_addr = 10'd0; #1;
    n_cmp++; if (vga_data !== 24'h0055AA) begin n_fail++; $display("FAIL disp_h0: got %h need 0055AA", vga_data); end
    valid = 1'b0; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0) begin n_fail++; $display("FAIL disp_blank: got %h need 000000", vga_data); end
  endtask

  task automatic test_line_end();
    bit ok;
    int bad;
    req_log.delete();
    run_line(10'd10);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hA100_7800 || fetch_busy !== 1'b1) begin n_fail++; $display("FAIL le_first_req: valid=%b addr=%h busy=%b need 1 A1007800 1", mem_req_valid, mem_req_addr, fetch_busy); end
    valid = 1'b1; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0554AA) begin n_fail++; $display("FAIL le_swap: got %h need 0554AA", vga_data); end
    valid = 1'b0;
    wait_idle(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL le_timeout: busy=%b need 0", fetch_busy); end
    bad = -1;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] !== 32'hA100_7800 + 32'(4 * i)) begin bad = i; break; end
    n_cmp++; if (req_log.size() != 640 || bad >= 0) begin n_fail++; $display("FAIL le_req_order: count=%0d first_bad=%0d need 640 from A1007800", req_log.size(), bad); end
  endtask

  task automatic test_wrap();
    bit ok;
    run_line(10'd478);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== FB) begin n_fail++; $display("FAIL wrap478_addr: valid=%b addr=%h need 1 %h", mem_req_valid, mem_req_addr, FB); end
    valid = 1'b1; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0559AA) begin n_fail++; $display("FAIL wrap478_disp: got %h need 0559AA", vga_data); end
    valid = 1'b0;
    wait_idle(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap478_timeout: busy=%b need 0", fetch_busy); end
    run_line(10'd479);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hA100_0A00) begin n_fail++; $display("FAIL wrap479_addr: valid=%b addr=%h need 1 A1000A00", mem_req_valid, mem_req_addr); end
    valid = 1'b1; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0555AA) begin n_fail++; $display("FAIL wrap479_disp: got %h need 0555AA", vga_data); end
    valid = 1'b0;
    wait_idle(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap479_timeout: busy=%b need 0", fetch_busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad, hold_err, holds, r0;
    logic [31:0] prev_addr;
    logic prev_hold;
    hold_err = 0; holds = 0; ok = 1'b0;
    req_log.delete();
    r0 = resp_total;
    mem_req_ready = 1'b1;
    run_line(10'd100);
    n_cmp++; if (mem_req_addr !== 32'hA103_FC00) begin n_fail++; $display("FAIL bp_first_addr: got %h need A103FC00", mem_req_addr); end
    for (int c = 0; c < 3000; c++) begin
      mem_req_ready = ~mem_req_ready;
      prev_addr = mem_req_addr;
      prev_hold = mem_req_valid & ~mem_req_ready;
      step();
      if (prev_hold && mem_req_valid) begin
        holds++;
        if (mem_req_addr !== prev_addr) hold_err++;
      end
      if (!fetch_busy) begin ok = 1'b1; break; end
    end
    mem_req_ready = 1'b1;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: busy=%b need 0", fetch_busy); end
    n_cmp++; if (hold_err != 0 || holds == 0) begin n_fail++; $display("FAIL bp_addr_hold: changes=%0d over %0d stalls need 0 over >0", hold_err, holds); end
    bad = -1;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] !== 32'hA103_FC00 + 32'(4 * i)) begin bad = i; break; end
    n_cmp++; if (req_log.size() != 640 || bad >= 0) begin n_fail++; $display("FAIL bp_req_order: count=%0d first_bad=%0d need 640 from A103FC00", req_log.size(), bad); end
    n_cmp++; if (resp_total - r0 != 640) begin n_fail++; $display("FAIL bp_resp_count: got %0d need 640", resp_total - r0); end
    run_line(10'd200);
    valid = 1'b1; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0533AA) begin n_fail++; $display("FAIL bp_buf_h5: got %h need 0533AA", vga_data); end
    h_addr = 10'd639; #1;
    n_cmp++; if (vga_data !== 24'h7F33AA) begin n_fail++; $display("FAIL bp_buf_h639: got %h need 7F33AA", vga_data); end
    h_addr = 10'd256; #1;
    n_cmp++; if (vga_data !== 24'h0033AA) begin n_fail++; $display("FAIL bp_buf_h256: got %h need 0033AA", vga_data); end
    valid = 1'b0;
    wait_idle(2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_line202_timeout: busy=%b need 0", fetch_busy); end
  endtask

  task automatic test_underrun();
    mem_req_ready = 1'b0;
    run_line(10'd300);
    n_cmp++; if (mem_req_addr !== 32'hA10B_CC00) begin n_fail++; $display("FAIL ur_first_addr: got %h need A10BCC00", mem_req_addr); end
    valid = 1'b1; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h059FAA) begin n_fail++; $display("FAIL ur_disp_before: got %h need 059FAA", vga_data); end
    valid = 1'b0;
    repeat (900) step();
    n_cmp++; if (underrun !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'hA10B_CC00) begin n_fail++; $display("FAIL ur_stall: underrun=%b valid=%b addr=%h need 0 1 A10BCC00", underrun, mem_req_valid, mem_req_addr); end
    run_line(10'd301);
    n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set: got %b need 1", underrun); end
    valid = 1'b1; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h059FAA) begin n_fail++; $display("FAIL ur_disp_kept: got %h need 059FAA", vga_data); end
    valid = 1'b0;
    repeat (10) step();
    n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b need 1", underrun); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b0; #1;
    n_cmp++; if (underrun !== 1'b0 || mem_req_valid !== 1'b0 || fetch_busy !== 1'b0 || mem_req_addr !== FB) begin n_fail++; $display("FAIL mr_async: underrun=%b valid=%b busy=%b addr=%h need 0 0 0 %h", underrun, mem_req_valid, fetch_busy, mem_req_addr, FB); end
    mem_req_ready = 1'b1;
    repeat (2) step();
    startup_sequence("restart");
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL mr_underrun: got %b need 0", underrun); end
    valid = 1'b1; v_addr = 10'd0; h_addr = 10'd5; #1;
    n_cmp++; if (vga_data !== 24'h0555AA) begin n_fail++; $display("FAIL mr_disp: got %h need 0555AA", vga_data); end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_display();
    test_line_end();
    test_wrap();
    test_backpressure();
    test_underrun();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Pixel source for the 640x480 VGA timing generator. It prefetches framebuffer lines from memory into a ping-pong pair of line buffers over a pipelined read interface. It serves the 24-bit colour for the current `h_addr`/`v_addr` combinationally, so the timing generator samples `vga_data` in the same cycle it presents the coordinates.

## Interface
- `H_PIXELS`, 640, visible pixels per line (words fetched per line)
- `V_LINES`, 480, visible lines per frame
- `FB_BASE`, 32'hA100_0000, byte address of pixel (0,0); one 32-bit word per pixel, format 0x00RRGGBB
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `h_addr`  in  10  current pixel column from the timing generator
- `v_addr`  in  10  current pixel row from the timing generator
- `valid`  in  1  timing generator in active video
- `vga_data`  out  24  colour {R,G,B} for (`h_addr`,`v_addr`)
- `mem_req_valid`  out  1  read request present
- `mem_req_ready`  in  1  memory accepts request this cycle
- `mem_req_addr`  out  32  byte address of requested word
- `mem_resp_valid`  in  1  read data returned, in request order, no backpressure
- `mem_resp_data`  in  32  returned word
- `fetch_busy`  out  1  a line fetch is in progress
- `underrun`  out  1  sticky: a line-end event arrived while busy

## Operation
- Storage: `buf[2][H_PIXELS]` x 24 bits. `disp_sel` picks the buffer being displayed. The fill buffer is `~disp_sel`.
- `vga_data = valid ? buf[disp_sel][h_addr][23:0] : 24'h0`. This is a combinational, asynchronous read.
- Line-end event: `valid_d & ~valid`, where `valid_d` is `valid` registered. `last_line` holds `v_addr`, registered on every cycle with `valid`=1.
- On a line-end event, if the FSM is IDLE:
  - toggle `disp_sel`
  - start a fetch of line `(last_line+2) mod V_LINES` into the new fill buffer.
  - Result: line 478 end fetches line 0; line 479 end fetches line 1.
- FSM states:
  - IDLE: waiting for a trigger.
  - REQ: issue requests while `req_cnt < H_PIXELS`.
  - DRAIN: all requests issued, `resp_cnt < H_PIXELS`.
  - Transitions: REQ -> DRAIN when the last request is accepted. DRAIN -> IDLE on the response that makes `resp_cnt == H_PIXELS`. REQ and DRAIN both go to IDLE in the same cycle if the final response and the final acceptance coincide.
- Requests:
  - `mem_req_valid` = 1 throughout REQ.
  - `mem_req_addr = FB_BASE + 4*(line*H_PIXELS + req_cnt)`. Maintain a running line-base register; do not use a multiplier in the critical path.
  - `req_cnt` increments only on `mem_req_valid & mem_req_ready`.
  - Address and valid stay stable while ready=0.
- Responses: on `mem_resp_valid` in REQ or DRAIN, write `mem_resp_data[23:0]` to `buf[~disp_sel][resp_cnt]` and increment `resp_cnt`. Responses in IDLE are discarded.
- Startup, after reset release:
  - fetch line 0 into buf0;
  - then fetch line 1 into buf1;
  - then go to IDLE with `disp_sel`=0.
  - Line-end events during startup are ignored and do not set `underrun`.
- Line-end event while REQ/DRAIN (not startup): the event is dropped, `disp_sel` is unchanged, and `underrun` is set to 1 and held until reset.
- Counters are 10 bits. `req_cnt`/`resp_cnt` clear at the start of each fetch.

## Timing
- Reset values:
  - `mem_req_valid`=0, `mem_req_addr`=FB_BASE, `fetch_busy`=0, `underrun`=0, `disp_sel`=0
  - FSM = IDLE with the startup pending
  - `vga_data`=0 because `valid` is low in blanking; buffer contents are undefined.
- First request: `mem_req_valid`=1 on the first rising edge after `rst` goes high, with address FB_BASE.
- `fetch_busy`=1 from the cycle REQ is entered through the cycle DRAIN exits. It is registered.
- Swap and fetch start: the event is detected on the first cycle with `valid`=0 after a line. `disp_sel` toggles and REQ is entered at the next edge, so the first request appears 1 cycle after `valid` falls.
- Throughput: 1 request per cycle when ready=1, so a line completes in H_PIXELS + memory latency. The budget is 800 cycles per line.
- Reset asserted mid-fetch clears everything asynchronously and restarts the startup sequence. The memory side must be reset with the same signal; stale responses after reset are not tolerated.

## Test plan
- Reset/startup:
  - Hold `rst`=0 and check all reset values.
  - Release with ready=1 and 2-cycle response latency. Requests must be 0xA1000000..0xA10009FC, then 0xA1000A00..0xA10013FC.
  - `fetch_busy` must fall after the 1280th response.
- Display read: preload line 0 = 0x00RRGGBB with R=x[7:0], G=0x55, B=0xAA. Drive `valid`=1, `v_addr`=0, `h_addr`=5 -> `vga_data`=0x0555AA. With `valid`=0 -> 0x000000.
- Line end: `valid` falls after `v_addr`=10 -> `disp_sel` toggles, and the first request address is FB_BASE + 4*12*640 = 0xA1007800.
- Wrap: line ends at 478 and 479 -> fetches start at FB_BASE (line 0) and then FB_BASE + 0xA00 (line 1).
- Backpressure: `mem_req_ready` toggling 1/0 -> `mem_req_addr` holds while ready=0. Exactly 640 requests and 640 buffer writes occur, in order.
- Underrun and mid-fetch reset:
  - ready=0 for 900 cycles, then a second line end -> `underrun`=1 and it stays, `disp_sel` is unchanged.
  - Assert `rst` mid-fetch -> `underrun`=0, and startup restarts at FB_BASE.
